// File: rtl/sr_display_receiver_if.sv
// Frame output bus of the 7-segment serial receiver: held frame, valid/ready
// handshake, status flags and optional glyph decode.
interface sr_display_receiver_if #(
    parameter int NUM_7_SEG_DISPLAYS = 5
);
    logic [8*NUM_7_SEG_DISPLAYS-1:0] o_segments;
    logic                            o_valid;
    logic                            i_ready;
    logic                            o_frame_error;
    logic                            o_overrun;
    logic [4*NUM_7_SEG_DISPLAYS-1:0] o_digits;
    logic [NUM_7_SEG_DISPLAYS-1:0]   o_blank;
    logic [NUM_7_SEG_DISPLAYS-1:0]   o_minus;
    logic                            o_glyph_err;

    modport master (
        output o_segments, o_valid, o_frame_error, o_overrun,
        output o_digits, o_blank, o_minus, o_glyph_err,
        input  i_ready
    );

    modport slave (
        input  o_segments, o_valid, o_frame_error, o_overrun,
        input  o_digits, o_blank, o_minus, o_glyph_err,
        output i_ready
    );
endinterface

// File: rtl/sr_display_receiver.sv
// Oversampling receiver for the data/shift-clock/latch 7-segment stream.
// Glyph decode outputs are built only when SR_RX_SEG_DECODE_EN is defined.
module sr_display_receiver #(
    parameter int NUM_7_SEG_DISPLAYS = 5,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sr_data,
    input  logic                 i_sr_clk,
    input  logic                 i_sr_latch,
    sr_display_receiver_if.master bus
);
    localparam int N          = NUM_7_SEG_DISPLAYS;
    localparam int FRAME_BITS = 8 * N;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_BITS + 1);

    logic [2:0]             line_in;
    logic [2:0]             sync_out;
    logic [SYNC_STAGES-1:0] prime_reg;
    logic                   primed;
    logic [1:0]             hist_reg;
    logic [1:0]             rise;
    logic                   clk_rise_reg;
    logic                   latch_rise_reg;
    logic                   data_reg;

    logic [FRAME_BITS-1:0]  shift_reg;
    logic [FRAME_BITS-1:0]  shift_next;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic [FRAME_BITS-1:0]  segments_reg;
    logic                   valid_reg;
    logic                   frame_error_reg;
    logic                   overrun_reg;
    logic                   frame_ok;
    logic                   accept;

    assign line_in = {i_sr_latch, i_sr_clk, i_sr_data};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] stages_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) stages_reg <= '0;
                else        stages_reg <= {stages_reg[SYNC_STAGES-2:0], line_in[gi]};
            end
            assign sync_out[gi] = stages_reg[SYNC_STAGES-1];
        end
    endgenerate

    // History is frozen at 1 until the synchronizers hold real post-reset
    // samples, so a line already high at reset release never looks like a rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prime_reg      <= '0;
            hist_reg       <= 2'b11;
            clk_rise_reg   <= 1'b0;
            latch_rise_reg <= 1'b0;
            data_reg       <= 1'b0;
        end else begin
            prime_reg      <= {prime_reg[SYNC_STAGES-2:0], 1'b1};
            if (primed) hist_reg <= sync_out[2:1];
            clk_rise_reg   <= rise[0];
            latch_rise_reg <= rise[1];
            data_reg       <= sync_out[0];
        end
    end

    assign primed = prime_reg[SYNC_STAGES-1];
    assign rise   = primed ? (sync_out[2:1] & ~hist_reg) : 2'b00;

    // A shift coinciding with the latch is folded in before the count is judged.
    assign shift_next = clk_rise_reg ? {shift_reg[FRAME_BITS-2:0], data_reg} : shift_reg;
    assign cnt_next   = (clk_rise_reg && bit_cnt_reg != CNT_SAT) ? bit_cnt_reg + 1'b1 : bit_cnt_reg;
    assign frame_ok   = latch_rise_reg && (cnt_next == CNT_FRAME);
    assign accept     = frame_ok && !valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            segments_reg    <= '0;
            valid_reg       <= 1'b0;
            frame_error_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            shift_reg       <= shift_next;
            bit_cnt_reg     <= latch_rise_reg ? '0 : cnt_next;
            frame_error_reg <= latch_rise_reg && !frame_ok;
            if (valid_reg && bus.i_ready) begin
                valid_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end
            // Judged against the pre-handshake valid, so a same-cycle
            // handshake still leaves the overrun flag set.
            if (accept) begin
                segments_reg <= shift_next;
                valid_reg    <= 1'b1;
            end else if (frame_ok) begin
                overrun_reg  <= 1'b1;
            end
        end
    end

    assign bus.o_segments    = segments_reg;
    assign bus.o_valid       = valid_reg;
    assign bus.o_frame_error = frame_error_reg;
    assign bus.o_overrun     = overrun_reg;

`ifdef SR_RX_SEG_DECODE_EN
    // Returns {not_a_glyph, minus, blank, nibble}; dp is not looked at.
    function automatic logic [6:0] decode_glyph(input logic [6:0] seg);
        logic [6:0] r;
        r = 7'h00;
        case (seg)
            7'h3F: r[3:0] = 4'h0;
            7'h06: r[3:0] = 4'h1;
            7'h5B: r[3:0] = 4'h2;
            7'h4F: r[3:0] = 4'h3;
            7'h66: r[3:0] = 4'h4;
            7'h6D: r[3:0] = 4'h5;
            7'h7D: r[3:0] = 4'h6;
            7'h07: r[3:0] = 4'h7;
            7'h7F: r[3:0] = 4'h8;
            7'h6F: r[3:0] = 4'h9;
            7'h77: r[3:0] = 4'hA;
            7'h7C: r[3:0] = 4'hB;
            7'h39: r[3:0] = 4'hC;
            7'h5E: r[3:0] = 4'hD;
            7'h79: r[3:0] = 4'hE;
            7'h71: r[3:0] = 4'hF;
            7'h00: r[4]   = 1'b1;
            7'h40: r[5]   = 1'b1;
            default: r[6] = 1'b1;
        endcase
        return r;
    endfunction

    logic [4*N-1:0] digits_next;
    logic [N-1:0]   blank_next;
    logic [N-1:0]   minus_next;
    logic [N-1:0]   err_next;
    logic [4*N-1:0] digits_reg;
    logic [N-1:0]   blank_reg;
    logic [N-1:0]   minus_reg;
    logic           glyph_err_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            logic [6:0] dec;
            assign dec                   = decode_glyph(shift_next[8*gi +: 7]);
            assign digits_next[4*gi +: 4] = dec[3:0];
            assign blank_next[gi]        = dec[4];
            assign minus_next[gi]        = dec[5];
            assign err_next[gi]          = dec[6];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_reg    <= '0;
            blank_reg     <= '0;
            minus_reg     <= '0;
            glyph_err_reg <= 1'b0;
        end else if (accept) begin
            digits_reg    <= digits_next;
            blank_reg     <= blank_next;
            minus_reg     <= minus_next;
            glyph_err_reg <= |err_next;
        end
    end

    assign bus.o_digits    = digits_reg;
    assign bus.o_blank     = blank_reg;
    assign bus.o_minus     = minus_reg;
    assign bus.o_glyph_err = glyph_err_reg;
`else
    assign bus.o_digits    = '0;
    assign bus.o_blank     = '0;
    assign bus.o_minus     = '0;
    assign bus.o_glyph_err = 1'b0;
`endif
endmodule
